// File: rtl/ffn_buffer_writer_pkg.sv
// ==== ffn_buffer_writer_pkg : shared sizing and state encoding (rev 1.0) ====
`default_nettype none

package ffn_buffer_writer_pkg;

  localparam int DEF_NUM_KERNELS = 2;
  localparam int DEF_KSEL_WIDTH  = 1;
  localparam int DEF_DATA_WIDTH  = 22;
  localparam int DEF_DEPTH       = 64;
  localparam int DEF_ADDR_WIDTH  = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/ffn_buffer_writer_if.sv
// ==== ffn_buffer_writer_if : result stream in, bank write port out (rev 1.0) ====
`default_nettype none

interface ffn_buffer_writer_if
  import ffn_buffer_writer_pkg::*;
#(
  parameter int NUM_KERNELS = DEF_NUM_KERNELS,
  parameter int KSEL_WIDTH  = DEF_KSEL_WIDTH,
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH
) ();

  logic                   frame_start;
  logic                   in_valid;
  logic                   in_ready;
  logic [KSEL_WIDTH-1:0]  in_kernel;
  logic [DATA_WIDTH-1:0]  in_data;
  logic [NUM_KERNELS-1:0] wr_en;
  logic [ADDR_WIDTH-1:0]  wr_addr;
  logic [DATA_WIDTH-1:0]  wr_data;
  logic [NUM_KERNELS-1:0] bank_full;
  logic                   frame_done;
  logic                   err_route;

  modport master (
    output frame_start, in_valid, in_kernel, in_data,
    input  in_ready, wr_en, wr_addr, wr_data, bank_full, frame_done, err_route
  );

  modport slave (
    input  frame_start, in_valid, in_kernel, in_data,
    output in_ready, wr_en, wr_addr, wr_data, bank_full, frame_done, err_route
  );

endinterface

`default_nettype wire

// File: rtl/ffn_buffer_writer_bank_fill_counter.sv
// ==== ffn_buffer_writer_bank_fill_counter : per-bank write address and full flag (rev 1.0) ====
`default_nettype none

module ffn_buffer_writer_bank_fill_counter
  import ffn_buffer_writer_pkg::*;
#(
  parameter int DEPTH      = DEF_DEPTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  wire                   clock,
  input  wire                   reset,
  input  wire                   clear,
  input  wire                   inc,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  full,
  output logic                  fill_now
);

  localparam logic [ADDR_WIDTH:0] LAST = (ADDR_WIDTH + 1)'(DEPTH - 1);

  logic [ADDR_WIDTH:0] count;

  assign addr     = count[ADDR_WIDTH-1:0];
  // High while the current increment is the one that completes the bank.
  assign fill_now = inc && !full && (count == LAST);

  always_ff @(posedge clock) begin
    if (!reset) begin
      count <= '0;
      full  <= 1'b0;
    end else if (clear) begin
      count <= '0;
      full  <= 1'b0;
    end else if (inc && !full) begin
      count <= count + 1'b1;
      if (count == LAST) full <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/ffn_buffer_writer.sv
// ==== ffn_buffer_writer : routes tagged kernel results into per-kernel buffer banks (rev 1.0) ====
`default_nettype none

module ffn_buffer_writer
  import ffn_buffer_writer_pkg::*;
#(
  parameter int NUM_KERNELS = DEF_NUM_KERNELS,
  parameter int KSEL_WIDTH  = DEF_KSEL_WIDTH,
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int DEPTH       = DEF_DEPTH,
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH
) (
  input wire                  clock,
  input wire                  reset,
  ffn_buffer_writer_if.slave  bus
);

  state_t                 state;
  logic [NUM_KERNELS-1:0] full;
  logic [NUM_KERNELS-1:0] fill_now;
  logic [NUM_KERNELS-1:0] hit;
  logic [ADDR_WIDTH-1:0]  bank_addr [NUM_KERNELS];
  logic [ADDR_WIDTH-1:0]  sel_addr;
  logic                   accept;
  logic                   kernel_ok;
  logic                   write;
  logic                   all_full_next;

  logic [NUM_KERNELS-1:0] wr_en_r;
  logic [ADDR_WIDTH-1:0]  wr_addr_r;
  logic [DATA_WIDTH-1:0]  wr_data_r;
  logic                   frame_done_r;
  logic                   err_route_r;

  // Ready depends only on state and frame_start so a restart never races a beat.
  assign bus.in_ready = (state == ST_FILL) && !bus.frame_start;
  assign accept       = bus.in_valid && bus.in_ready;
  assign kernel_ok    = 32'(bus.in_kernel) < NUM_KERNELS;

  always_comb begin
    hit      = '0;
    sel_addr = '0;
    for (int i = 0; i < NUM_KERNELS; i++) begin
      if (accept && kernel_ok && (32'(bus.in_kernel) == i) && !full[i]) begin
        hit[i]   = 1'b1;
        sel_addr = bank_addr[i];
      end
    end
  end

  assign write         = |hit;
  assign all_full_next = &(full | fill_now);

  for (genvar g = 0; g < NUM_KERNELS; g++) begin : g_bank
    ffn_buffer_writer_bank_fill_counter #(
      .DEPTH      (DEPTH),
      .ADDR_WIDTH (ADDR_WIDTH)
    ) u_fill (
      .clock    (clock),
      .reset    (reset),
      .clear    (bus.frame_start),
      .inc      (hit[g]),
      .addr     (bank_addr[g]),
      .full     (full[g]),
      .fill_now (fill_now[g])
    );
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state        <= ST_IDLE;
      wr_en_r      <= '0;
      wr_addr_r    <= '0;
      wr_data_r    <= '0;
      frame_done_r <= 1'b0;
      err_route_r  <= 1'b0;
    end else begin
      wr_en_r <= hit;
      if (write) begin
        wr_addr_r <= sel_addr;
        wr_data_r <= bus.in_data;
      end
      // Misrouted or excess beats are still consumed, only flagged.
      if (accept && !write) err_route_r <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (bus.frame_start) state <= ST_FILL;
        end
        ST_FILL: begin
          if (bus.frame_start) begin
            state <= ST_FILL;
          end else if (write && all_full_next) begin
            state        <= ST_DONE;
            frame_done_r <= 1'b1;
          end
        end
        ST_DONE: begin
          if (bus.frame_start) begin
            state        <= ST_FILL;
            frame_done_r <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.wr_en      = wr_en_r;
  assign bus.wr_addr    = wr_addr_r;
  assign bus.wr_data    = wr_data_r;
  assign bus.bank_full  = full;
  assign bus.frame_done = frame_done_r;
  assign bus.err_route  = err_route_r;

endmodule

`default_nettype wire

// File: tb/tb_ffn_buffer_writer.sv
// ==== tb_ffn_buffer_writer : random and directed stimulus against a fill-count reference model (rev 1.0) ====
`default_nettype none

module tb_ffn_buffer_writer;

  localparam int NK    = 2;
  localparam int KW    = 2;
  localparam int DW    = 22;
  localparam int DEPTH = 64;
  localparam int AW    = 6;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  ffn_buffer_writer_if #(
    .NUM_KERNELS (NK), .KSEL_WIDTH (KW), .DATA_WIDTH (DW), .ADDR_WIDTH (AW)
  ) bus ();

  ffn_buffer_writer #(
    .NUM_KERNELS (NK), .KSEL_WIDTH (KW), .DATA_WIDTH (DW), .DEPTH (DEPTH), .ADDR_WIDTH (AW)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Reference model: words stored per bank, frame mode (0 idle, 1 fill, 2 done)
  int            cnt [NK];
  int            mode;
  bit            err_m;
  logic [NK-1:0] exp_wr_en;
  int            last_addr;
  logic [DW-1:0] last_data;
  int            writes_model;
  int            writes_seen;
  logic [DW-1:0] mem [NK][DEPTH];

  int tests = 0;
  int fails = 0;

  always @(negedge clock) begin
    for (int i = 0; i < NK; i++) begin
      if (bus.wr_en[i]) begin
        mem[i][bus.wr_addr] = bus.wr_data;
        writes_seen++;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    logic [NK-1:0] full_m;
    for (int i = 0; i < NK; i++) full_m[i] = (cnt[i] == DEPTH);
    check("wr_en", bus.wr_en, exp_wr_en);
    check("wr_addr", bus.wr_addr, last_addr);
    check("wr_data", bus.wr_data, last_data);
    check("bank_full", bus.bank_full, full_m);
    check("frame_done", bus.frame_done, mode == 2);
    check("err_route", bus.err_route, err_m);
  endtask

  task automatic cycle(input bit fs, input bit v, input int k, input logic [DW-1:0] d);
    bit ready_m;
    bit acc;
    bit all_full;
    bus.frame_start = fs;
    bus.in_valid    = v;
    bus.in_kernel   = KW'(k);
    bus.in_data     = d;
    #1;
    ready_m = (mode == 1) && !fs;
    check("in_ready", bus.in_ready, ready_m);
    acc       = v && ready_m;
    exp_wr_en = '0;
    if (acc) begin
      if (k < NK && cnt[k] < DEPTH) begin
        exp_wr_en[k] = 1'b1;
        last_addr    = cnt[k];
        last_data    = d;
        cnt[k]++;
        writes_model++;
        all_full = 1'b1;
        for (int i = 0; i < NK; i++) if (cnt[i] != DEPTH) all_full = 1'b0;
        if (all_full) mode = 2;
      end else begin
        err_m = 1'b1;
      end
    end
    if (fs) begin
      mode = 1;
      for (int i = 0; i < NK; i++) cnt[i] = 0;
    end
    @(posedge clock);
    #1;
    bus.frame_start = 1'b0;
    bus.in_valid    = 1'b0;
    check_outputs();
  endtask

  // Assert reset for one edge with a beat offered; everything must clear.
  task automatic do_reset();
    reset           = 1'b0;
    bus.frame_start = 1'b0;
    bus.in_valid    = 1'b1;
    bus.in_kernel   = '0;
    bus.in_data     = DW'(22'h2AAAAA);
    @(posedge clock);
    #1;
    mode      = 0;
    err_m     = 1'b0;
    exp_wr_en = '0;
    last_addr = 0;
    last_data = '0;
    for (int i = 0; i < NK; i++) cnt[i] = 0;
    check("reset_in_ready", bus.in_ready, 1'b0);
    check_outputs();
    reset        = 1'b1;
    bus.in_valid = 1'b0;
  endtask

  initial begin
    writes_model    = 0;
    writes_seen     = 0;
    bus.frame_start = 1'b0;
    bus.in_valid    = 1'b0;
    bus.in_kernel   = '0;
    bus.in_data     = '0;

    do_reset();

    // Full frame, alternating kernels, data = beat index
    cycle(1, 0, 0, '0);
    for (int i = 0; i < 2 * DEPTH; i++) cycle(0, 1, i % 2, DW'(i));
    check("frame_done_after_128", bus.frame_done, 1'b1);
    @(negedge clock);
    #1;
    for (int i = 0; i < DEPTH; i++) begin
      check("bank0_word", mem[0][i], 2 * i);
      check("bank1_word", mem[1][i], 2 * i + 1);
    end
    for (int i = 0; i < 3; i++) cycle(0, 1, 0, DW'(500 + i));

    // Overfill bank 0: the 65th beat is swallowed and flagged
    cycle(1, 0, 0, '0);
    for (int i = 0; i < DEPTH; i++) cycle(0, 1, 0, DW'(1000 + i));
    cycle(0, 1, 0, DW'(2000));
    check("overfill_bank_full", bus.bank_full, 2'b01);
    check("overfill_err", bus.err_route, 1'b1);
    cycle(0, 0, 0, '0);

    // Out-of-range kernel index from a clean reset
    do_reset();
    cycle(1, 0, 0, '0);
    cycle(0, 1, 3, DW'(77));
    check("bad_kernel_err", bus.err_route, 1'b1);
    cycle(0, 1, 1, DW'(78));
    check("bad_kernel_next_addr", bus.wr_addr, 0);

    // Restart mid-frame with a beat offered on the frame_start cycle
    cycle(1, 0, 0, '0);
    for (int i = 0; i < 10; i++) cycle(0, 1, 1, DW'(300 + i));
    cycle(1, 1, 1, DW'(399));
    cycle(0, 1, 1, DW'(400));
    check("restart_addr", bus.wr_addr, 0);

    // Reset after 30 writes, then beats are ignored until frame_start
    cycle(1, 0, 0, '0);
    for (int i = 0; i < 30; i++) cycle(0, 1, i % 2, DW'(600 + i));
    do_reset();
    for (int i = 0; i < 3; i++) cycle(0, 1, i % 2, DW'(700 + i));
    cycle(1, 0, 0, '0);

    // Random valid, kernel, data and occasional restarts
    for (int i = 0; i < 900; i++) begin
      cycle($urandom_range(0, 99) == 0, 1'($urandom_range(0, 1)),
            ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, 1), DW'($urandom));
    end

    @(negedge clock);
    #1;
    check("total_writes", writes_seen, writes_model);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ffn_buffer_writer.md
# ffn_buffer_writer

Write-side counterpart of the FFN input read mux. Accepts a valid/ready stream of kernel results tagged with a kernel index and writes each word into that kernel's SRAM buffer bank at that bank's next sequential address. It tracks per-bank fill, flags misrouted or excess beats, and signals frame completion so the FFN stage can start reading. It sits between the convolution kernels and the per-kernel FFN input buffers.

## Interface
- NUM_KERNELS, 2, number of buffer banks (one per kernel)
- KSEL_WIDTH, 1, width of kernel index, >= clog2(NUM_KERNELS), min 1
- DATA_WIDTH, 22, buffer word width (FFN input word)
- DEPTH, 64, words per bank per frame
- ADDR_WIDTH, 6, bank address width, 2^ADDR_WIDTH >= DEPTH
- clock  input  1  rising-edge clock
- reset  input  1  reset, synchronous, active-low
- frame_start  input  1  one-cycle pulse: clear fill state, begin accepting a frame
- in_valid  input  1  beat valid
- in_ready  output  1  beat accepted when in_valid && in_ready
- in_kernel  input  KSEL_WIDTH  destination bank index
- in_data  input  DATA_WIDTH  word to store
- wr_en  output  NUM_KERNELS  one-hot bank write strobe
- wr_addr  output  ADDR_WIDTH  write address, shared by all banks
- wr_data  output  DATA_WIDTH  write data, shared by all banks
- bank_full  output  NUM_KERNELS  bank has received DEPTH words this frame
- frame_done  output  1  all banks full; held until next frame_start
- err_route  output  1  sticky: beat to full bank or in_kernel >= NUM_KERNELS

## Operation
- States: IDLE, FILL, DONE.
- IDLE: in_ready=0. frame_start -> FILL, counters and bank_full cleared.
- FILL: in_ready = !frame_start. Per accepted beat with k = in_kernel:
  - k < NUM_KERNELS and !bank_full[k]: register wr_en = 1<<k, wr_addr = count[k], wr_data = in_data; count[k]++; count[k] reaching DEPTH sets bank_full[k].
  - otherwise: beat consumed, no write, err_route set.
  - When the beat fills the last non-full bank -> DONE.
- DONE: in_ready=0, frame_done=1. frame_start -> FILL with counters/bank_full cleared.
- frame_start in FILL: restart; in_ready=0 that cycle, so no beat is accepted; counters cleared.
- err_route cleared only by reset; frame_start does not clear it.
- Counters are ADDR_WIDTH+1 bits; no wrap, saturate at DEPTH via bank_full.
- Reset (any state, mid-frame included): state IDLE, wr_en=0, wr_addr=0, wr_data=0, bank_full=0, frame_done=0, err_route=0, counters 0, in_ready=0.

## Timing
- in_ready combinational from state and frame_start only, never from in_valid.
- Write latency 1: wr_en/wr_addr/wr_data valid the cycle after handshake, wr_en high exactly one cycle per write.
- bank_full[k] and the DONE transition update on the same edge that issues the last write; frame_done rises the same cycle as the final wr_en; in_ready low that cycle.
- Full throughput: one write per cycle with in_valid held.
- wr_addr/wr_data hold last value when wr_en=0.

## Structure
- Shared header: NUM_KERNELS, FFN input word width, per-bank depth, address width; state encoding local constants.
- Optional sub-module bank_fill_counter (per-bank count + full flag), instantiated NUM_KERNELS times via generate; otherwise single module.

## Test plan
- Reset then frame_start, 128 beats alternating kernel 0/1, data = beat index -> bank0 writes addr 0..63 data 0,2,..,126; bank1 addr 0..63 data 1,..,127; frame_done rises with 128th wr_en.
- 64 beats to kernel 0 then one more to kernel 0 -> bank_full=2'b01, 65th consumed with no wr_en, err_route=1, state stays FILL.
- in_kernel=3 with KSEL_WIDTH=2, NUM_KERNELS=2 -> no write, err_route=1, counters unchanged.
- 10 beats to kernel 1, frame_start with in_valid high -> in_ready=0 that cycle, next beat to kernel 1 writes addr 0.
- reset low mid-frame after 30 writes -> next cycle all outputs 0, IDLE; beats ignored until frame_start.
- in_valid toggled randomly in FILL -> wr_en count equals handshake count, addresses contiguous per bank.
